// File: rtl/compressed_align_ctrl.sv
// RV32C fetch-alignment controller: slices fetch words into 16/32-bit instructions,
// buffers straddling halves and reports the alignment class plus fetch-PC hold.
module compressed_align_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RST_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] fetch_word,
    input  logic            fetch_valid,
    input  logic            pipe_stall,
    input  logic            flush,
    input  logic            flush_pc_half,
    output logic [XLEN-1:0] inst_out,
    output logic            inst_valid,
    output logic            inst_compressed,
    output logic            f1f1,
    output logic            f1f2,
    output logic            hf,
    output logic            fh,
    output logic            hh,
    output logic            stall_compressed
);

    localparam int unsigned HALF = 16;
    localparam int unsigned NFLG = 5;

    localparam logic [NFLG-1:0] FL_NONE = 5'b00000;
    localparam logic [NFLG-1:0] FL_F1F1 = 5'b10000;
    localparam logic [NFLG-1:0] FL_F1F2 = 5'b01000;
    localparam logic [NFLG-1:0] FL_HF   = 5'b00100;
    localparam logic [NFLG-1:0] FL_FH   = 5'b00010;
    localparam logic [NFLG-1:0] FL_HH   = 5'b00001;

    typedef enum logic [1:0] {
        S_ALIGN = 2'd0,
        S_PEND  = 2'd1,
        S_UPPER = 2'd2,
        S_ODD   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [HALF-1:0]     r_half_buf;
    logic [HALF-1:0]     r_held_hi;
    logic                r_cls_fh;
    logic                w_buf_ld;
    logic                w_held_ld;
    logic                w_cls_ld;
    logic                w_cls_fh_nxt;

    logic [XLEN-1:0]     r_inst_out;
    logic                r_inst_valid;
    logic                r_inst_comp;
    logic [NFLG-1:0]     r_flags;
    logic                r_stall;

    logic [XLEN-1:0]     w_inst_out;
    logic                w_inst_valid;
    logic                w_inst_comp;
    logic [NFLG-1:0]     w_flags;
    logic                w_stall;

    logic [HALF-1:0]     w_lo;
    logic [HALF-1:0]     w_hi;
    logic                w_lo_32;
    logic                w_hi_32;

    assign w_lo    = fetch_word[HALF-1:0];
    assign w_hi    = fetch_word[2*HALF-1:HALF];
    assign w_lo_32 = (w_lo[1:0] == 2'b11);
    assign w_hi_32 = (w_hi[1:0] == 2'b11);

    // State register: flush beats pipe_stall, pipe_stall freezes everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_ALIGN;
        end else if (flush) begin
            r_state <= flush_pc_half ? S_ODD : S_ALIGN;
        end else if (!pipe_stall) begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            r_half_buf <= '0;
            r_held_hi  <= '0;
            r_cls_fh   <= 1'b0;
        end else if (!pipe_stall) begin
            if (w_buf_ld)  r_half_buf <= w_hi;
            if (w_held_ld) r_held_hi  <= w_hi;
            if (w_cls_ld)  r_cls_fh   <= w_cls_fh_nxt;
        end
    end

    // Last presented outputs, replayed while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_inst_out   <= RST_INST;
            r_inst_valid <= 1'b0;
            r_inst_comp  <= 1'b0;
            r_flags      <= FL_NONE;
            r_stall      <= 1'b0;
        end else begin
            r_inst_out   <= inst_out;
            r_inst_valid <= inst_valid;
            r_inst_comp  <= inst_compressed;
            r_flags      <= {f1f1, f1f2, hf, fh, hh};
            r_stall      <= stall_compressed;
        end
    end

    // Next-state and buffer-load decode.
    always_comb begin
        w_next_state = r_state;
        w_buf_ld     = 1'b0;
        w_held_ld    = 1'b0;
        w_cls_ld     = 1'b0;
        w_cls_fh_nxt = 1'b0;
        case (r_state)
            S_ALIGN: begin
                if (fetch_valid && !w_lo_32) begin
                    if (w_hi_32) begin
                        w_buf_ld     = 1'b1;
                        w_next_state = S_PEND;
                    end else begin
                        w_held_ld    = 1'b1;
                        w_cls_ld     = 1'b1;
                        w_next_state = S_UPPER;
                    end
                end
            end
            S_PEND: begin
                if (fetch_valid) begin
                    if (w_hi_32) begin
                        w_buf_ld     = 1'b1;
                    end else begin
                        w_held_ld    = 1'b1;
                        w_cls_ld     = 1'b1;
                        w_cls_fh_nxt = 1'b1;
                        w_next_state = S_UPPER;
                    end
                end
            end
            S_UPPER: begin
                w_next_state = S_ALIGN;
            end
            S_ODD: begin
                if (fetch_valid) begin
                    w_buf_ld     = w_hi_32;
                    w_next_state = w_hi_32 ? S_PEND : S_ALIGN;
                end
            end
            default: w_next_state = S_ALIGN;
        endcase
    end

    // Output decode, then reset/flush/stall overrides.
    always_comb begin
        w_inst_out   = '0;
        w_inst_valid = 1'b0;
        w_inst_comp  = 1'b0;
        w_flags      = FL_NONE;
        w_stall      = 1'b0;
        case (r_state)
            S_ALIGN: begin
                if (fetch_valid) begin
                    w_inst_valid = 1'b1;
                    if (w_lo_32) begin
                        w_inst_out = fetch_word;
                        w_flags    = FL_F1F1;
                    end else begin
                        w_inst_out  = XLEN'(w_lo);
                        w_inst_comp = 1'b1;
                        w_flags     = w_hi_32 ? FL_HF : FL_HH;
                        w_stall     = !w_hi_32;
                    end
                end
            end
            S_PEND: begin
                if (fetch_valid) begin
                    w_inst_valid = 1'b1;
                    w_inst_out   = XLEN'({w_lo, r_half_buf});
                    w_flags      = w_hi_32 ? FL_F1F2 : FL_FH;
                    w_stall      = !w_hi_32;
                end
            end
            S_UPPER: begin
                w_inst_valid = 1'b1;
                w_inst_out   = XLEN'(r_held_hi);
                w_inst_comp  = 1'b1;
                w_flags      = r_cls_fh ? FL_FH : FL_HH;
            end
            S_ODD: begin
                if (fetch_valid && !w_hi_32) begin
                    w_inst_valid = 1'b1;
                    w_inst_out   = XLEN'(w_hi);
                    w_inst_comp  = 1'b1;
                end
            end
            default: ;
        endcase

        if (!reset_n) begin
            w_inst_out   = RST_INST;
            w_inst_valid = 1'b0;
            w_inst_comp  = 1'b0;
            w_flags      = FL_NONE;
            w_stall      = 1'b0;
        end else if (flush) begin
            w_inst_out   = '0;
            w_inst_valid = 1'b0;
            w_inst_comp  = 1'b0;
            w_flags      = FL_NONE;
            w_stall      = 1'b0;
        end else if (pipe_stall) begin
            w_inst_out   = r_inst_out;
            w_inst_valid = r_inst_valid;
            w_inst_comp  = r_inst_comp;
            w_flags      = r_flags;
            w_stall      = r_stall;
        end
    end

    assign inst_out         = w_inst_out;
    assign inst_valid       = w_inst_valid;
    assign inst_compressed  = w_inst_comp;
    assign {f1f1, f1f2, hf, fh, hh} = w_flags;
    assign stall_compressed = w_stall;

endmodule

// File: tb/tb_compressed_align_ctrl.sv
// Scoreboard bench for compressed_align_ctrl: driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_compressed_align_ctrl;

    logic        clk;
    logic        reset_n;
    logic [31:0] fetch_word;
    logic        fetch_valid;
    logic        pipe_stall;
    logic        flush;
    logic        flush_pc_half;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        inst_compressed;
    logic        f1f1, f1f2, hf, fh, hh;
    logic        stall_compressed;

    compressed_align_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .fetch_word       (fetch_word),
        .fetch_valid      (fetch_valid),
        .pipe_stall       (pipe_stall),
        .flush            (flush),
        .flush_pc_half    (flush_pc_half),
        .inst_out         (inst_out),
        .inst_valid       (inst_valid),
        .inst_compressed  (inst_compressed),
        .f1f1             (f1f1),
        .f1f2             (f1f2),
        .hf               (hf),
        .fh               (fh),
        .hh               (hh),
        .stall_compressed (stall_compressed)
    );

    // Flag vector order: {f1f1, f1f2, hf, fh, hh}
    localparam logic [4:0] N  = 5'b00000;
    localparam logic [4:0] FF = 5'b10000;
    localparam logic [4:0] F2 = 5'b01000;
    localparam logic [4:0] HF = 5'b00100;
    localparam logic [4:0] FH = 5'b00010;
    localparam logic [4:0] HH = 5'b00001;

    typedef struct {
        string       name;
        logic        val;
        logic        chk_inst;
        logic [31:0] inst;
        logic        comp;
        logic [4:0]  flags;
        logic        stall;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [4:0] got_flags;
            logic ok;
            e = exp_q.pop_front();
            got_flags = {f1f1, f1f2, hf, fh, hh};
            ok = (inst_valid == e.val) && (inst_compressed == e.comp) &&
                 (got_flags == e.flags) && (stall_compressed == e.stall) &&
                 (!e.chk_inst || inst_out == e.inst);
            n_checks++;
            if (ok) n_pass++;
            else $display("FAIL %s: got val=%0b inst=%h comp=%0b flags=%b stall=%0b, want val=%0b inst=%h comp=%0b flags=%b stall=%0b",
                          e.name, inst_valid, inst_out, inst_compressed, got_flags, stall_compressed,
                          e.val, e.inst, e.comp, e.flags, e.stall);
        end
    end

    task automatic cyc(input string nm, input logic rst_n, input logic fv, input logic [31:0] w,
                       input logic ps, input logic fl, input logic fph,
                       input logic e_val, input logic e_chk, input logic [31:0] e_inst,
                       input logic e_comp, input logic [4:0] e_flags, input logic e_stall);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = rst_n; fetch_valid = fv; fetch_word = w;
        pipe_stall = ps; flush = fl; flush_pc_half = fph;
        e.name = nm; e.val = e_val; e.chk_inst = e_chk; e.inst = e_inst;
        e.comp = e_comp; e.flags = e_flags; e.stall = e_stall;
        exp_q.push_back(e);
    endtask

    initial begin
        reset_n = 1'b0; fetch_valid = 1'b0; fetch_word = '0;
        pipe_stall = 1'b0; flush = 1'b0; flush_pc_half = 1'b0;

        //   name          rst fv word          ps fl fph  val chk inst          comp flags stall
        cyc("reset0",      0, 1, 32'h00A00093, 0, 0, 0,   0, 1, 32'h00000013, 0, N,  0);
        cyc("reset1",      0, 1, 32'h00A00093, 0, 0, 0,   0, 1, 32'h00000013, 0, N,  0);
        cyc("aligned",     1, 1, 32'h00A00093, 0, 0, 0,   1, 1, 32'h00A00093, 0, FF, 0);
        cyc("hh_lo",       1, 1, 32'h45054585, 0, 0, 0,   1, 1, 32'h00004585, 1, HH, 1);
        cyc("hh_hi",       1, 0, 32'h00000000, 0, 0, 0,   1, 1, 32'h00004505, 1, HH, 0);
        cyc("idle_align",  1, 0, 32'h00A00093, 0, 0, 0,   0, 0, 32'h0,        0, N,  0);
        cyc("hf",          1, 1, 32'h00934585, 0, 0, 0,   1, 1, 32'h00004585, 1, HF, 0);
        cyc("fh",          1, 1, 32'h450500A0, 0, 0, 0,   1, 1, 32'h00A00093, 0, FH, 1);
        cyc("fh_upper",    1, 0, 32'h00000000, 0, 0, 0,   1, 1, 32'h00004505, 1, FH, 0);
        cyc("chain_hf",    1, 1, 32'h00934585, 0, 0, 0,   1, 1, 32'h00004585, 1, HF, 0);
        cyc("idle_pend",   1, 0, 32'h450500A0, 0, 0, 0,   0, 0, 32'h0,        0, N,  0);
        cyc("f1f2",        1, 1, 32'h011300A0, 0, 0, 0,   1, 1, 32'h00A00093, 0, F2, 0);
        cyc("f1f2_buf",    1, 1, 32'h450500A0, 0, 0, 0,   1, 1, 32'h00A00113, 0, FH, 1);
        cyc("f1f2_upper",  1, 0, 32'h00000000, 0, 0, 0,   1, 1, 32'h00004505, 1, FH, 0);
        cyc("pre_stall",   1, 1, 32'h00A00093, 0, 0, 0,   1, 1, 32'h00A00093, 0, FF, 0);
        cyc("stall_hold",  1, 1, 32'h45054585, 1, 0, 0,   1, 1, 32'h00A00093, 0, FF, 0);
        cyc("post_stall",  1, 1, 32'h45054585, 0, 0, 0,   1, 1, 32'h00004585, 1, HH, 1);
        cyc("flush_upper", 1, 1, 32'h45054585, 1, 1, 1,   0, 0, 32'h0,        0, N,  0);
        cyc("odd_c",       1, 1, 32'h45050000, 0, 0, 0,   1, 1, 32'h00004505, 1, N,  0);
        cyc("odd_to_align",1, 1, 32'h00A00093, 0, 0, 0,   1, 1, 32'h00A00093, 0, FF, 0);
        cyc("flush_odd",   1, 0, 32'h00000000, 0, 1, 1,   0, 0, 32'h0,        0, N,  0);
        cyc("odd_idle",    1, 0, 32'h00930000, 0, 0, 0,   0, 0, 32'h0,        0, N,  0);
        cyc("odd_32",      1, 1, 32'h00930000, 0, 0, 0,   0, 0, 32'h0,        0, N,  0);
        cyc("odd_pend_fh", 1, 1, 32'h450500A0, 0, 0, 0,   1, 1, 32'h00A00093, 0, FH, 1);
        cyc("odd_upper",   1, 0, 32'h00000000, 0, 0, 0,   1, 1, 32'h00004505, 1, FH, 0);
        cyc("pend_hf",     1, 1, 32'h00934585, 0, 0, 0,   1, 1, 32'h00004585, 1, HF, 0);
        cyc("flush_pend",  1, 1, 32'h450500A0, 0, 1, 0,   0, 0, 32'h0,        0, N,  0);
        cyc("after_flush", 1, 1, 32'h00A00093, 0, 0, 0,   1, 1, 32'h00A00093, 0, FF, 0);
        cyc("idle_end",    1, 0, 32'h00000000, 0, 0, 0,   0, 0, 32'h0,        0, N,  0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
            n_checks++;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
